apb_master_n: RTL and testbench
===============================

Name: apb_master_n

Overview:
- Parametrised APB3 bridge between the RV32I core's simple bus (transfer/ready/write/addr/wdata/rdata) and NUM_SLAVES APB peripherals.
- Next generation of the fixed five-slave APB master used in the MCU top level.
- Adds a parametric address map, PSLVERR propagation, an error response for unmapped addresses, a PREADY timeout watchdog, and back-to-back transfers without an IDLE bubble.

Parameters:
- NUM_SLAVES, 5, number of APB slaves (1..16); slave i sits at BASE_ADDR + i*2^REGION_BITS.
- BASE_ADDR, 32'h1000_0000, base of slave 0; must be aligned to 2^REGION_BITS.
- REGION_BITS, 12, log2 of the per-slave window size in bytes.
- TIMEOUT_CYCLES, 255, maximum ACCESS cycles without PREADY before abort; 0 disables the watchdog.

Ports:
- PCLK  in  1  clock.
- PRESET  in  1  reset. Asynchronous, active-high.
- transfer  in  1  CPU request strobe; sampled in IDLE and in the completing ACCESS cycle.
- write  in  1  1 = write, 0 = read.
- addr  in  32  byte address.
- wdata  in  32  write data.
- rdata  out  32  read data; valid when ready=1.
- ready  out  1  transfer complete, one-cycle pulse per transfer.
- err  out  1  qualifies ready: slave PSLVERR, unmapped address, or timeout.
- PADDR  out  32  latched address.
- PWRITE  out  1  latched direction.
- PWDATA  out  32  latched write data.
- PENABLE  out  1  APB enable.
- PSEL  out  NUM_SLAVES  one-hot select.
- PRDATA  in  32*NUM_SLAVES  slave i data on bits [32i+31:32i].
- PREADY  in  NUM_SLAVES  per-slave ready.
- PSLVERR  in  NUM_SLAVES  per-slave error.

Behaviour:
- Reset (async, while PRESET=1) sets:
  - state=IDLE.
  - PADDR, PWDATA, PWRITE, PENABLE, PSEL all 0.
  - Timeout counter 0.
  - ready=0, err=0, rdata=0.
- Decode:
  - idx = (addr - BASE_ADDR) >> REGION_BITS.
  - The address is mapped iff addr >= BASE_ADDR and idx < NUM_SLAVES.
  - The decode result is latched with the address.
- State machine IDLE, SETUP, ACCESS, ERROR:
  - IDLE: on transfer=1, latch addr/wdata/write and the decode result. If mapped, go to SETUP; if unmapped, go to ERROR.
  - SETUP: PSEL[idx]=1, PENABLE=0. Always go to ACCESS next cycle.
  - ACCESS: PSEL[idx]=1, PENABLE=1. When PREADY[idx]=1:
    - ready=1 combinationally in the same cycle.
    - rdata = PRDATA slice idx.
    - err = PSLVERR[idx].
    - If transfer=1 in this cycle, latch the new request and go to SETUP (or ERROR if unmapped); otherwise go to IDLE.
  - ERROR: no PSEL, PENABLE=0. ready=1, err=1, rdata=0 for one cycle, then go to IDLE. Requests arriving in ERROR are ignored.
- Latency:
  - Zero-wait slave: request in cycle T, ready in cycle T+2.
  - Each cycle of PREADY=0 adds one cycle.
  - Unmapped address: ready in cycle T+1.
- Timeout:
  - The counter clears on entering ACCESS and increments each ACCESS cycle with PREADY[idx]=0.
  - When the counter reaches TIMEOUT_CYCLES (TIMEOUT_CYCLES>0), go to ERROR next cycle. PSEL and PENABLE drop in that cycle.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- PREADY and PSLVERR of non-selected slaves are ignored. rdata=0 whenever ready=0.
- In IDLE, PADDR, PWDATA and PWRITE hold their last values; only PSEL and PENABLE return to 0.
- PSEL is always one-hot or zero; there is never more than one bit set.
- Reset asserted mid-ACCESS aborts the transfer immediately, with no ready pulse. The first cycle after reset release is IDLE.
- Address wrap: addr below BASE_ADDR makes the subtraction underflow; it must be detected via the compare, not the index.

Decomposition:
- Package apb_pkg holds:
  - typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ERROR} apb_state_e.
  - localparam APB_DW=32, APB_AW=32.
  - The default BASE_ADDR and REGION_BITS constants shared with peripherals and the MCU top.
- Sub-module apb_addr_decoder (combinational): addr in; idx and mapped out.
- The FSM, latches, timeout counter and PRDATA/PSLVERR mux stay in apb_master_n.

Test Plan:
- Write, zero-wait: transfer with addr=0x1000_2004, wdata=0xA5A5_0001 to slave 2 (PREADY=1) -> PSEL=5'b00100 at T+1 with PENABLE=0; PENABLE=1 at T+2; ready=1, err=0 at T+2; PWDATA=0xA5A5_0001.
- Read, wait states: read 0x1000_3000 with slave 3 holding PREADY low for 2 ACCESS cycles and PRDATA3=0x1234_5678 -> ready at T+4, rdata=0x1234_5678; rdata=0 in all other cycles.
- Unmapped address: transfer addr=0x1000_5000 (NUM_SLAVES=5) and separately addr=0x0FFF_FFFC -> no PSEL bit set; ready=1, err=1, rdata=0 at T+1.
- Error and timeout: slave 1 asserts PSLVERR with PREADY -> err=1 on the ready cycle. With TIMEOUT_CYCLES=4 and slave 0 PREADY stuck low -> 4 ACCESS cycles, then ERROR cycle with ready=1, err=1; PSEL=0 in that cycle.
- Back-to-back: transfer held during the completing ACCESS of a write to slave 0, next a read from slave 4 -> SETUP for slave 4 on the following cycle with no IDLE gap; two ready pulses 2 cycles apart.
- Reset mid-transfer: assert PRESET during ACCESS -> PSEL, PENABLE and ready are 0 asynchronously; after release, a new transfer completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths, default peripheral address map and the
// bridge state encoding used by the MCU top level and its peripherals.
package apb_pkg;

    localparam int APB_DW = 32;
    localparam int APB_AW = 32;

    localparam logic [APB_AW-1:0] APB_BASE_ADDR   = 32'h1000_0000;
    localparam int                APB_REGION_BITS = 12;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        ERROR
    } apb_state_e;

endpackage

// File: rtl/apb_addr_decoder.sv
// Maps a CPU byte address onto a slave index and reports whether it hits any
// slave window at all.
module apb_addr_decoder
    import apb_pkg::*;
#(
    parameter int                NUM_SLAVES  = 5,
    parameter logic [APB_AW-1:0] BASE_ADDR   = APB_BASE_ADDR,
    parameter int                REGION_BITS = APB_REGION_BITS,
    parameter int                IDX_W       = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
    input  logic [APB_AW-1:0] addr_i,
    output logic [IDX_W-1:0]  idx_o,
    output logic              mapped_o
);

    logic [APB_AW-1:0] offset;
    logic [APB_AW-1:0] region;

    // Addresses below the base wrap around in the subtraction, so the lower
    // bound has to come from the direct compare rather than the region number.
    always_comb begin
        offset   = addr_i - BASE_ADDR;
        region   = offset >> REGION_BITS;
        mapped_o = (addr_i >= BASE_ADDR) && (region < APB_AW'(NUM_SLAVES));
        idx_o    = region[IDX_W-1:0];
    end

endmodule

// File: rtl/apb_master_n.sv
// APB3 bridge from the core's transfer/ready bus to NUM_SLAVES peripherals,
// with slave-error, unmapped-address and PREADY-timeout error responses.
module apb_master_n
    import apb_pkg::*;
#(
    parameter int                NUM_SLAVES     = 5,
    parameter logic [APB_AW-1:0] BASE_ADDR      = APB_BASE_ADDR,
    parameter int                REGION_BITS    = APB_REGION_BITS,
    parameter int                TIMEOUT_CYCLES = 255
) (
    input  logic                         PCLK,
    input  logic                         PRESET,
    input  logic                         transfer,
    input  logic                         write,
    input  logic [APB_AW-1:0]            addr,
    input  logic [APB_DW-1:0]            wdata,
    output logic [APB_DW-1:0]            rdata,
    output logic                         ready,
    output logic                         err,
    output logic [APB_AW-1:0]            PADDR,
    output logic                         PWRITE,
    output logic [APB_DW-1:0]            PWDATA,
    output logic                         PENABLE,
    output logic [NUM_SLAVES-1:0]        PSEL,
    input  logic [APB_DW*NUM_SLAVES-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]        PREADY,
    input  logic [NUM_SLAVES-1:0]        PSLVERR
);

    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    apb_state_e          state_q, state_d;
    logic [APB_AW-1:0]   paddr_q, paddr_d;
    logic [APB_DW-1:0]   pwdata_q, pwdata_d;
    logic                pwrite_q, pwrite_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [IDX_W-1:0]      dec_idx;
    logic                  dec_mapped;
    logic [NUM_SLAVES-1:0] sel_onehot;
    logic                  pready_sel;
    logic                  pslverr_sel;
    logic [APB_DW-1:0]     prdata_sel;

    apb_addr_decoder #(
        .NUM_SLAVES  (NUM_SLAVES),
        .BASE_ADDR   (BASE_ADDR),
        .REGION_BITS (REGION_BITS),
        .IDX_W       (IDX_W)
    ) u_decoder (
        .addr_i   (addr),
        .idx_o    (dec_idx),
        .mapped_o (dec_mapped)
    );

    assign PADDR  = paddr_q;
    assign PWDATA = pwdata_q;
    assign PWRITE = pwrite_q;

    // Only the latched slave's handshake and data are ever looked at.
    always_comb begin
        sel_onehot  = '0;
        pready_sel  = 1'b0;
        pslverr_sel = 1'b0;
        prdata_sel  = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_onehot[i] = 1'b1;
                pready_sel    = PREADY[i];
                pslverr_sel   = PSLVERR[i];
                prdata_sel    = PRDATA[APB_DW*i +: APB_DW];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pwrite_d = pwrite_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        PSEL     = '0;
        PENABLE  = 1'b0;
        ready    = 1'b0;
        err      = 1'b0;
        rdata    = '0;

        case (state_q)
            IDLE: begin
                if (transfer) begin
                    paddr_d  = addr;
                    pwdata_d = wdata;
                    pwrite_d = write;
                    idx_d    = dec_idx;
                    state_d  = dec_mapped ? SETUP : ERROR;
                end
            end
            SETUP: begin
                PSEL    = sel_onehot;
                cnt_d   = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                PSEL    = sel_onehot;
                PENABLE = 1'b1;
                if (pready_sel) begin
                    ready = 1'b1;
                    err   = pslverr_sel;
                    rdata = prdata_sel;
                    // A request held through the completing cycle chains
                    // straight into the next SETUP with no IDLE bubble.
                    if (transfer) begin
                        paddr_d  = addr;
                        pwdata_d = wdata;
                        pwrite_d = write;
                        idx_d    = dec_idx;
                        state_d  = dec_mapped ? SETUP : ERROR;
                    end else begin
                        state_d = IDLE;
                    end
                end else if ((TIMEOUT_CYCLES > 0) && (cnt_q == CNT_LAST)) begin
                    state_d = ERROR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ERROR: begin
                ready   = 1'b1;
                err     = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q  <= IDLE;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
            idx_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            pwrite_q <= pwrite_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_apb_master_n.sv
// Bench for apb_master_n: directed scenarios plus randomized transfers checked
// against a cycle-count model of the APB protocol.
module tb_apb_master_n;

    localparam int          NS   = 5;
    localparam int          TO   = 4;
    localparam logic [31:0] BASE = 32'h1000_0000;

    logic            PCLK = 1'b0;
    logic            PRESET = 1'b1;
    logic            transfer = 1'b0;
    logic            write = 1'b0;
    logic [31:0]     addr = '0;
    logic [31:0]     wdata = '0;
    logic [31:0]     rdata;
    logic            ready;
    logic            err;
    logic [31:0]     PADDR;
    logic            PWRITE;
    logic [31:0]     PWDATA;
    logic            PENABLE;
    logic [NS-1:0]   PSEL;
    logic [32*NS-1:0] PRDATA = '0;
    logic [NS-1:0]   PREADY = '0;
    logic [NS-1:0]   PSLVERR = '0;

    int errors = 0;
    int checks = 0;

    apb_master_n #(
        .NUM_SLAVES     (NS),
        .BASE_ADDR      (BASE),
        .REGION_BITS    (12),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .transfer (transfer),
        .write    (write),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .ready    (ready),
        .err      (err),
        .PADDR    (PADDR),
        .PWRITE   (PWRITE),
        .PWDATA   (PWDATA),
        .PENABLE  (PENABLE),
        .PSEL     (PSEL),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic test_reset();
        PRESET = 1'b1;
        repeat (2) @(negedge PCLK);
        #1;
        checks++; if (PSEL !== '0) begin errors++; $display("[TB] FAIL rst_psel: got %b expected 0", PSEL); end
        checks++; if (PENABLE !== 1'b0) begin errors++; $display("[TB] FAIL rst_penable: got %b expected 0", PENABLE); end
        checks++; if (ready !== 1'b0 || err !== 1'b0) begin errors++; $display("[TB] FAIL rst_ready_err: got %b%b expected 00", ready, err); end
        checks++; if (rdata !== '0) begin errors++; $display("[TB] FAIL rst_rdata: got %h expected 0", rdata); end
        checks++; if (PADDR !== '0 || PWDATA !== '0 || PWRITE !== 1'b0) begin errors++; $display("[TB] FAIL rst_latches: got %h %h %b expected zeros", PADDR, PWDATA, PWRITE); end
        @(negedge PCLK);
        PRESET = 1'b0;
    endtask

    task automatic test_write_zero_wait();
        @(negedge PCLK);
        transfer = 1'b1; write = 1'b1; addr = 32'h1000_2004; wdata = 32'hA5A5_0001;
        PREADY = 5'b00100; PSLVERR = '0;
        #1;
        checks++; if (PSEL !== '0 || ready !== 1'b0) begin errors++; $display("[TB] FAIL wz_idle: got psel=%b ready=%b expected 0/0", PSEL, ready); end
        @(negedge PCLK);
        transfer = 1'b0;
        #1;
        checks++; if (PSEL !== 5'b00100) begin errors++; $display("[TB] FAIL wz_setup_psel: got %b expected 00100", PSEL); end
        checks++; if (PENABLE !== 1'b0 || ready !== 1'b0) begin errors++; $display("[TB] FAIL wz_setup_en: got pen=%b ready=%b expected 0/0", PENABLE, ready); end
        checks++; if (PADDR !== 32'h1000_2004 || PWRITE !== 1'b1) begin errors++; $display("[TB] FAIL wz_setup_addr: got %h/%b expected 10002004/1", PADDR, PWRITE); end
        @(negedge PCLK);
        #1;
        checks++; if (PENABLE !== 1'b1 || PSEL !== 5'b00100) begin errors++; $display("[TB] FAIL wz_access: got pen=%b psel=%b expected 1/00100", PENABLE, PSEL); end
        checks++; if (ready !== 1'b1 || err !== 1'b0) begin errors++; $display("[TB] FAIL wz_ready: got ready=%b err=%b expected 1/0", ready, err); end
        checks++; if (PWDATA !== 32'hA5A5_0001) begin errors++; $display("[TB] FAIL wz_pwdata: got %h expected a5a50001", PWDATA); end
        @(negedge PCLK);
        PREADY = '0;
        #1;
        checks++; if (ready !== 1'b0 || PSEL !== '0 || PENABLE !== 1'b0) begin errors++; $display("[TB] FAIL wz_idle_after: got ready=%b psel=%b pen=%b expected 0", ready, PSEL, PENABLE); end
        checks++; if (PADDR !== 32'h1000_2004 || PWDATA !== 32'hA5A5_0001) begin errors++; $display("[TB] FAIL wz_hold: got %h/%h expected held values", PADDR, PWDATA); end
    endtask

    task automatic test_read_wait();
        @(negedge PCLK);
        transfer = 1'b1; write = 1'b0; addr = 32'h1000_3000; PREADY = '0; PSLVERR = '0;
        PRDATA = {$urandom, $urandom, $urandom, $urandom, $urandom};
        PRDATA[96 +: 32] = 32'h1234_5678;
        #1;
        checks++; if (rdata !== '0) begin errors++; $display("[TB] FAIL rw_rdata_c0: got %h expected 0", rdata); end
        for (int c = 1; c <= 5; c++) begin
            @(negedge PCLK);
            transfer = 1'b0;
            PREADY[3] = (c == 4);
            #1;
            checks++; if (ready !== (c == 4)) begin errors++; $display("[TB] FAIL rw_ready c%0d: got %b expected %b", c, ready, (c == 4)); end
            checks++; if (rdata !== ((c == 4) ? 32'h1234_5678 : 32'h0)) begin errors++; $display("[TB] FAIL rw_rdata c%0d: got %h expected %h", c, rdata, ((c == 4) ? 32'h1234_5678 : 32'h0)); end
            checks++; if (PSEL !== ((c <= 4) ? 5'b01000 : 5'b00000)) begin errors++; $display("[TB] FAIL rw_psel c%0d: got %b", c, PSEL); end
        end
        PREADY = '0;
    endtask

    task automatic test_unmapped();
        logic [31:0] addrs [2];
        addrs[0] = 32'h1000_5000;
        addrs[1] = 32'h0FFF_FFFC;
        for (int k = 0; k < 2; k++) begin
            @(negedge PCLK);
            transfer = 1'b1; write = 1'b0; addr = addrs[k]; PREADY = '1;
            PRDATA = {$urandom, $urandom, $urandom, $urandom, $urandom};
            #1;
            checks++; if (PSEL !== '0) begin errors++; $display("[TB] FAIL um%0d_idle_psel: got %b expected 0", k, PSEL); end
            @(negedge PCLK);
            #1;
            checks++; if (ready !== 1'b1 || err !== 1'b1) begin errors++; $display("[TB] FAIL um%0d_resp: got ready=%b err=%b expected 1/1", k, ready, err); end
            checks++; if (rdata !== '0 || PSEL !== '0 || PENABLE !== 1'b0) begin errors++; $display("[TB] FAIL um%0d_bus: got rdata=%h psel=%b pen=%b expected 0", k, rdata, PSEL, PENABLE); end
            @(negedge PCLK);
            transfer = 1'b0;
            #1;
            checks++; if (ready !== 1'b0 || PSEL !== '0) begin errors++; $display("[TB] FAIL um%0d_after: got ready=%b psel=%b expected 0/0", k, ready, PSEL); end
        end
        PREADY = '0;
    endtask

    task automatic test_slverr();
        for (int k = 0; k < 2; k++) begin
            @(negedge PCLK);
            transfer = 1'b1; write = 1'b1; addr = 32'h1000_1000; wdata = $urandom;
            PREADY = 5'b00010;
            PSLVERR = (k == 0) ? 5'b00010 : 5'b11101;
            @(negedge PCLK);
            transfer = 1'b0;
            @(negedge PCLK);
            #1;
            checks++; if (ready !== 1'b1 || err !== (k == 0)) begin errors++; $display("[TB] FAIL slverr%0d: got ready=%b err=%b expected 1/%b", k, ready, err, (k == 0)); end
        end
        @(negedge PCLK);
        PREADY = '0; PSLVERR = '0;
    endtask

    task automatic test_timeout();
        @(negedge PCLK);
        transfer = 1'b1; write = 1'b0; addr = 32'h1000_0010; PREADY = 5'b11110; PSLVERR = '0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge PCLK);
            transfer = 1'b0;
            #1;
            checks++; if (PSEL !== ((c <= 5) ? 5'b00001 : 5'b00000)) begin errors++; $display("[TB] FAIL to_psel c%0d: got %b", c, PSEL); end
            checks++; if (PENABLE !== (c >= 2 && c <= 5)) begin errors++; $display("[TB] FAIL to_penable c%0d: got %b expected %b", c, PENABLE, (c >= 2 && c <= 5)); end
            checks++; if (ready !== (c == 6) || err !== (c == 6)) begin errors++; $display("[TB] FAIL to_resp c%0d: got ready=%b err=%b expected %b", c, ready, err, (c == 6)); end
        end
        PREADY = '0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] val;
        val = $urandom;
        @(negedge PCLK);
        transfer = 1'b1; write = 1'b1; addr = 32'h1000_0000; wdata = $urandom; PREADY = '1; PSLVERR = '0;
        PRDATA = {$urandom, $urandom, $urandom, $urandom, $urandom};
        PRDATA[128 +: 32] = val;
        @(negedge PCLK);
        transfer = 1'b0;
        #1;
        checks++; if (PSEL !== 5'b00001) begin errors++; $display("[TB] FAIL b2b_setup0: got %b expected 00001", PSEL); end
        @(negedge PCLK);
        transfer = 1'b1; write = 1'b0; addr = 32'h1000_4008;
        #1;
        checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready0: got %b expected 1", ready); end
        @(negedge PCLK);
        transfer = 1'b0;
        #1;
        checks++; if (PSEL !== 5'b10000 || PENABLE !== 1'b0 || ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_setup4: got psel=%b pen=%b ready=%b expected 10000/0/0", PSEL, PENABLE, ready); end
        checks++; if (PADDR !== 32'h1000_4008 || PWRITE !== 1'b0) begin errors++; $display("[TB] FAIL b2b_addr4: got %h/%b expected 10004008/0", PADDR, PWRITE); end
        @(negedge PCLK);
        #1;
        checks++; if (ready !== 1'b1 || rdata !== val) begin errors++; $display("[TB] FAIL b2b_ready4: got ready=%b rdata=%h expected 1/%h", ready, rdata, val); end
        @(negedge PCLK);
        PREADY = '0;
        #1;
        checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_done: got %b expected 0", ready); end
    endtask

    task automatic test_reset_mid();
        @(negedge PCLK);
        transfer = 1'b1; write = 1'b0; addr = 32'h1000_3010; PREADY = '0;
        @(negedge PCLK);
        transfer = 1'b0;
        @(negedge PCLK);
        #1;
        checks++; if (PENABLE !== 1'b1) begin errors++; $display("[TB] FAIL rm_pre: got pen=%b expected 1", PENABLE); end
        PREADY = 5'b01000;
        PRESET = 1'b1;
        #1;
        checks++; if (PSEL !== '0 || PENABLE !== 1'b0 || ready !== 1'b0) begin errors++; $display("[TB] FAIL rm_async: got psel=%b pen=%b ready=%b expected 0", PSEL, PENABLE, ready); end
        @(negedge PCLK);
        PRESET = 1'b0; PREADY = '0;
        #1;
        checks++; if (PSEL !== '0 || ready !== 1'b0) begin errors++; $display("[TB] FAIL rm_release: got psel=%b ready=%b expected 0", PSEL, ready); end
        @(negedge PCLK);
        transfer = 1'b1; write = 1'b1; addr = 32'h1000_3020; wdata = 32'hCAFE_F00D; PREADY = 5'b01000;
        @(negedge PCLK);
        transfer = 1'b0;
        @(negedge PCLK);
        #1;
        checks++; if (ready !== 1'b1 || err !== 1'b0 || PADDR !== 32'h1000_3020) begin errors++; $display("[TB] FAIL rm_after: got ready=%b err=%b paddr=%h expected 1/0/10003020", ready, err, PADDR); end
        @(negedge PCLK);
        PREADY = '0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            int             cls;
            int             waits;
            int             sidx;
            int             done;
            int             selEnd;
            bit             slverr;
            bit             mapped;
            bit             timeout;
            bit             expErr;
            logic [31:0]    prd;
            logic [31:0]    expData;
            logic [NS-1:0]  pr;
            logic [NS-1:0]  ps;
            longint         a;

            cls = int'($urandom_range(0, 3));
            waits = int'($urandom_range(0, 5));
            slverr = 1'($urandom);
            prd = $urandom;
            if (cls <= 1)
                addr = BASE + (32'($urandom_range(0, NS - 1)) << 12) + (32'($urandom_range(0, 1023)) << 2);
            else if (cls == 2)
                addr = 32'($urandom_range(0, 32'h0FFF_FFFF));
            else
                addr = 32'h1000_5000 + 32'($urandom_range(0, 32'h7FFF_FFFF));
            write = 1'($urandom);
            wdata = $urandom;

            a = longint'({32'h0, addr});
            mapped = (a >= longint'({32'h0, BASE})) && ((a - longint'({32'h0, BASE})) / 4096 < NS);
            sidx = mapped ? int'((a - longint'({32'h0, BASE})) / 4096) : 0;
            timeout = mapped && (waits >= TO);
            done = !mapped ? 1 : (timeout ? 2 + TO : 2 + waits);
            selEnd = !mapped ? -1 : (timeout ? 1 + TO : done);
            expErr = !mapped || timeout || slverr;
            expData = (!mapped || timeout) ? 32'h0 : prd;

            for (int c = 0; c <= done + 1; c++) begin
                @(negedge PCLK);
                transfer = (c == 0);
                PRDATA = {$urandom, $urandom, $urandom, $urandom, $urandom};
                PRDATA[32*sidx +: 32] = prd;
                ps = NS'($urandom);
                ps[sidx] = slverr;
                PSLVERR = ps;
                pr = NS'($urandom);
                if (c >= 2) pr[sidx] = (c == 2 + waits);
                PREADY = pr;
                #1;
                checks++; if (ready !== (c == done)) begin errors++; $display("[TB] FAIL rnd%0d_ready c%0d: got %b expected %b addr=%h", n, c, ready, (c == done), addr); end
                checks++; if (rdata !== ((c == done) ? expData : 32'h0)) begin errors++; $display("[TB] FAIL rnd%0d_rdata c%0d: got %h expected %h", n, c, rdata, ((c == done) ? expData : 32'h0)); end
                checks++; if (PSEL !== ((mapped && c >= 1 && c <= selEnd) ? (NS'(1) << sidx) : NS'(0))) begin errors++; $display("[TB] FAIL rnd%0d_psel c%0d: got %b addr=%h", n, c, PSEL, addr); end
                if (c == done) begin
                    checks++; if (err !== expErr) begin errors++; $display("[TB] FAIL rnd%0d_err: got %b expected %b addr=%h waits=%0d", n, err, expErr, addr, waits); end
                end
            end
        end
        PREADY = '0; PSLVERR = '0; transfer = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_wait();
        test_unmapped();
        test_slverr();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
